inst_fetch_buf: RTL

- Instruction-fetch initiator for the MIPS core. Owns the PC, drives chip-enable and byte address into the combinational instruction ROM, and captures the returned word the same cycle.
- Buffers fetched {pc, inst} pairs in a 2-entry queue and presents them to the ID stage with a valid/ready handshake.
- Accepts branch redirects from ID/EX, which flush the queue.

---
 rtl/inst_fetch_buf_if.sv | 34 +++
 rtl/inst_fetch_buf.sv | 122 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_buf_if
// Purpose  : Bundles the ROM fetch port, the redirect request and the ID-stage
//            handshake of the instruction-fetch buffer.
//            master = fetch buffer side, slave = ROM / ID / EX side.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_buf_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_inst_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              id_ready_i;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              misalign_o;

  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, misalign_o,
    input  rom_inst_i, branch_flag_i, branch_target_i, id_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, misalign_o,
    output rom_inst_i, branch_flag_i, branch_target_i, id_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_buf
// Purpose  : Owns the PC, fetches from a combinational instruction ROM and
//            buffers {pc, inst} pairs in a 2-entry FIFO towards the ID stage.
//            Branch redirects flush the FIFO and reload the PC.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  wire logic           clk,
  input  wire logic           rst,
  inst_fetch_buf_if.master    bus
);

  // Architectural state
  logic              r_ce;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_e0_pc,   r_e1_pc;    // entry 0 is the FIFO head
  logic [INST_W-1:0] r_e0_inst, r_e1_inst;
  logic              r_misalign;

  // Next-state values
  logic              w_valid;
  logic              w_pop;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [1:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] w_e0_pc_nxt,   w_e1_pc_nxt;
  logic [INST_W-1:0] w_e0_inst_nxt, w_e1_inst_nxt;

  // Handshake decode and FIFO/PC next-state; a redirect overrides fetch and pop
  always_comb begin
    w_valid       = (r_cnt != 2'd0);
    w_pop         = w_valid && bus.id_ready_i;
    w_fetch       = r_ce && !bus.branch_flag_i && ((r_cnt != 2'd2) || w_pop);
    w_pc_nxt      = r_pc;
    w_cnt_nxt     = r_cnt;
    w_e0_pc_nxt   = r_e0_pc;
    w_e0_inst_nxt = r_e0_inst;
    w_e1_pc_nxt   = r_e1_pc;
    w_e1_inst_nxt = r_e1_inst;

    if (bus.branch_flag_i) begin
      w_cnt_nxt = 2'd0;
      w_pc_nxt  = {bus.branch_target_i[ADDR_W-1:2], 2'b00};
    end else begin
      if (w_fetch) begin
        w_pc_nxt = r_pc + ADDR_W'(4);
      end
      case ({w_pop, w_fetch})
        2'b11: begin
          // Count unchanged; the new word lands behind whatever remains
          if (r_cnt == 2'd2) begin
            w_e0_pc_nxt   = r_e1_pc;
            w_e0_inst_nxt = r_e1_inst;
            w_e1_pc_nxt   = r_pc;
            w_e1_inst_nxt = bus.rom_inst_i;
          end else begin
            w_e0_pc_nxt   = r_pc;
            w_e0_inst_nxt = bus.rom_inst_i;
          end
        end
        2'b10: begin
          // Popping the last entry leaves the stale head visible
          if (r_cnt == 2'd2) begin
            w_e0_pc_nxt   = r_e1_pc;
            w_e0_inst_nxt = r_e1_inst;
          end
          w_cnt_nxt = r_cnt - 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd0) begin
            w_e0_pc_nxt   = r_pc;
            w_e0_inst_nxt = bus.rom_inst_i;
          end else begin
            w_e1_pc_nxt   = r_pc;
            w_e1_inst_nxt = bus.rom_inst_i;
          end
          w_cnt_nxt = r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ce       <= 1'b0;
      r_pc       <= RESET_PC;
      r_cnt      <= 2'd0;
      r_e0_pc    <= '0;
      r_e0_inst  <= '0;
      r_e1_pc    <= '0;
      r_e1_inst  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_ce       <= 1'b1;
      r_pc       <= w_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_e0_pc    <= w_e0_pc_nxt;
      r_e0_inst  <= w_e0_inst_nxt;
      r_e1_pc    <= w_e1_pc_nxt;
      r_e1_inst  <= w_e1_inst_nxt;
      r_misalign <= bus.branch_flag_i && (bus.branch_target_i[1:0] != 2'b00);
    end
  end

  assign bus.rom_ce_o   = r_ce;
  assign bus.rom_addr_o = r_pc;
  assign bus.id_valid_o = w_valid;
  assign bus.id_pc_o    = r_e0_pc;
  assign bus.id_inst_o  = r_e0_inst;
  assign bus.misalign_o = r_misalign;

endmodule
`default_nettype wire
